scaler_snapshot_sequencer: RTL

//  Sequences channel reads of the scaler (A1) for two requesters and returns a coherent 28-bit count.

---
 rtl/scaler_snapshot_sequencer_pkg.sv | 23 ++
 rtl/scaler_snapshot_sequencer_rr_arbiter2.sv | 31 +++
 rtl/scaler_snapshot_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/scaler_snapshot_sequencer_pkg.sv
// Shared widths and FSM encoding for the scaler snapshot sequencer.
// The read-state helper keeps the strobe counter logic readable in the top.
package scaler_snapshot_sequencer_pkg;

   localparam int SCALER_HALF_W = 14;
   localparam int SNAP_W        = 28;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RDA   = 3'd1,
      ST_GAPA  = 3'd2,
      ST_RDB   = 3'd3,
      ST_GAPB  = 3'd4,
      ST_RDA2  = 3'd5,
      ST_GAPA2 = 3'd6,
      ST_DONE  = 3'd7
   } state_t;

   function automatic logic is_read(input state_t s);
      return (s == ST_RDA) || (s == ST_RDB) || (s == ST_RDA2);
   endfunction

endpackage

// File: rtl/scaler_snapshot_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: picks the favoured requester on contention,
// and moves the favour to the other requester only when a grant completes.
module rr_arbiter2
   import scaler_snapshot_sequencer_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic       i_upd,
   input  logic       i_upd_idx,
   output logic       o_gnt_idx
);

   logic r_prio;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prio <= 1'b0;
      end else if (i_upd) begin
         r_prio <= ~i_upd_idx;
      end
   end

   always_comb begin
      o_gnt_idx = i_req[1];
      if (i_req == 2'b11) begin
         o_gnt_idx = r_prio;
      end
   end

endmodule

// File: rtl/scaler_snapshot_sequencer.sv
// Reads the scaler high half, low half, then high half again, retrying on a
// high-half mismatch so the 28-bit snapshot never straddles a carry.
module scaler_snapshot_sequencer
   import scaler_snapshot_sequencer_pkg::*;
#(
   parameter int STROBE_CYCLES = 2,
   parameter int MAX_RETRY     = 3
) (
   input  logic                     CLOCK,
   input  logic                     rst_,
   input  logic [1:0]               req,
   output logic [1:0]               ack,
   output logic [SNAP_W-1:0]        snap_data,
   output logic                     snap_torn,
   output logic                     RCHAT_,
   output logic                     RCHBT_,
   input  logic [SCALER_HALF_W-1:0] chat_in,
   input  logic [SCALER_HALF_W-1:0] chbt_in
);

   localparam int               CNT_W     = $clog2(STROBE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

   state_t                   r_state;
   state_t                   w_next;
   logic [CNT_W-1:0]         r_cnt;
   logic [2:0]               r_retry;
   logic                     r_grant;
   logic [SCALER_HALF_W-1:0] r_hia;
   logic [SCALER_HALF_W-1:0] r_hib;
   logic [SCALER_HALF_W-1:0] r_lo;
   logic                     r_rchat_n;
   logic                     r_rchbt_n;
   logic [1:0]               r_ack;
   logic [SNAP_W-1:0]        r_snap;
   logic                     r_torn;
   logic                     w_gnt_idx;
   logic                     w_reading;
   logic                     w_last;
   logic                     w_match;
   logic                     w_can_retry;

   rr_arbiter2 u_arb (
      .i_clk     (CLOCK),
      .i_rst_n   (rst_),
      .i_req     (req),
      .i_upd     (r_state == ST_DONE),
      .i_upd_idx (r_grant),
      .o_gnt_idx (w_gnt_idx)
   );

   assign w_reading   = is_read(r_state);
   assign w_last      = w_reading && (r_cnt == CNT_LAST);
   assign w_match     = (r_hia == r_hib);
   assign w_can_retry = (r_retry < RETRY_MAX);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (|req)  w_next = ST_RDA;
         ST_RDA:   if (w_last) w_next = ST_GAPA;
         ST_GAPA:  w_next = ST_RDB;
         ST_RDB:   if (w_last) w_next = ST_GAPB;
         ST_GAPB:  w_next = ST_RDA2;
         ST_RDA2:  if (w_last) w_next = ST_GAPA2;
         ST_GAPA2: w_next = (w_match || !w_can_retry) ? ST_DONE : ST_RDB;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Strobes and ack are decoded from the next state so they leave flops directly.
   always_ff @(posedge CLOCK or negedge rst_) begin
      if (!rst_) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_retry   <= 3'd0;
         r_grant   <= 1'b0;
         r_hia     <= '0;
         r_hib     <= '0;
         r_lo      <= '0;
         r_rchat_n <= 1'b1;
         r_rchbt_n <= 1'b1;
         r_ack     <= 2'b00;
         r_snap    <= '0;
         r_torn    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= (w_reading && !w_last) ? r_cnt + CNT_W'(1) : '0;
         r_rchat_n <= !((w_next == ST_RDA) || (w_next == ST_RDA2));
         r_rchbt_n <= !(w_next == ST_RDB);
         r_ack     <= 2'b00;
         if ((r_state == ST_IDLE) && (|req)) begin
            r_grant <= w_gnt_idx;
         end
         if (w_last) begin
            case (r_state)
               ST_RDA:  r_hia <= chat_in;
               ST_RDB:  r_lo  <= chbt_in;
               ST_RDA2: r_hib <= chat_in;
               default: ;
            endcase
         end
         // A retry re-reads only the low half and then the high half again.
         if ((r_state == ST_GAPA2) && !w_match && w_can_retry) begin
            r_hia   <= r_hib;
            r_retry <= r_retry + 3'd1;
         end
         if (r_state == ST_DONE) begin
            r_retry <= 3'd0;
         end
         if (w_next == ST_DONE) begin
            r_ack  <= r_grant ? 2'b10 : 2'b01;
            r_snap <= {r_hia, r_lo};
            r_torn <= !w_match;
         end
      end
   end

   assign ack       = r_ack;
   assign snap_data = r_snap;
   assign snap_torn = r_torn;
   assign RCHAT_    = r_rchat_n;
   assign RCHBT_    = r_rchbt_n;

endmodule
